timgen_frame_seq: RTL and testbench
===================================

Name: timgen_frame_seq

Overview:
- Parametrised frame readout sequencer for the CCD/AFE timing path, running entirely on clk_pix.
- On a trigger it produces one complete frame:
  - dummy flush lines first, then active lines;
  - each line is a horizontal blanking interval containing N vertical transfers, followed by an active pixel interval.
- Generalises the fixed-geometry timing generator:
  - configurable geometry;
  - run-time vertical binning (1-4 rows per output line);
  - a busy/done handshake.
- Drives the AFE framing strobes (afe_hd, afe_pblk, afe_clpob, afe_vd), the CCD vertical clocks (ccd_v1, ccd_v2) and the CPU sync signals (cpu_hsync, cpu_vsync).

Parameters:
- H_ACTIVE, 4000, active pixel cycles per line.
- H_BLANK, 96, blanking cycles per line; must be > VXFER_LEN.
- V_LINES, 2700, active (output) lines per frame.
- V_DUMMY, 8, flush lines before the active lines; 0 is allowed.
- VXFER_LEN, 16, cycles per vertical transfer; must be even and >= 2.
- CLPOB_LEN, 16, optical-black clamp cycles at the start of each active interval; must be <= H_ACTIVE.

Ports:
- clk_pix  in  1  pixel clock; the only clock.
- rst  in  1  synchronous reset, active high.
- trigger  in  1  frame start request; sampled in IDLE only.
- vbin  in  2  vertical binning; rows per output line = vbin+1; sampled with trigger.
- busy  out  1  high from the cycle after trigger acceptance until the done pulse.
- done  out  1  one-cycle pulse at frame end.
- afe_hd  out  1  active-low line start strobe, 1 cycle.
- afe_pblk  out  1  active-low blanking (low = blanked).
- afe_clpob  out  1  active-low optical-black clamp window.
- afe_vd  out  1  active-low frame start strobe, 1 cycle.
- ccd_v1  out  1  vertical clock phase 1.
- ccd_v2  out  1  vertical clock phase 2.
- cpu_hsync  out  1  high during active pixels of active lines.
- cpu_vsync  out  1  high across all active lines.

Behaviour:
- Reset values (rst high at an edge):
  - afe_hd=1, afe_pblk=0, afe_clpob=1, afe_vd=1;
  - ccd_v1=0, ccd_v2=0;
  - cpu_hsync=0, cpu_vsync=0;
  - busy=0, done=0;
  - state=IDLE, all counters cleared.
- rst mid-frame aborts the frame immediately. No done pulse is issued.
- Counters:
  - h_cnt runs 0..H_BLANK+H_ACTIVE-1;
  - l_cnt counts lines within the current phase;
  - widths are $clog2 of the respective ranges.
- Every output is registered and decoded from the (state, h_cnt, l_cnt) of the previous cycle. Output cycle k therefore appears 1 clock after counter cycle k.
- FSM:
  - IDLE: if trigger=1 at an edge, latch nb=vbin+1 and go to FLUSH. If V_DUMMY=0, go to READ instead.
  - FLUSH: runs V_DUMMY lines, then goes to READ with l_cnt=0.
  - READ: runs V_LINES lines, then goes to FIN.
  - FIN: lasts one cycle; done=1 and busy=0 on its output cycle; then returns to IDLE.
- trigger is ignored outside IDLE. A trigger still high in IDLE after FIN starts a new frame.
- busy=1 on every output cycle of FLUSH and READ.
- afe_vd=0 only on the first output cycle of the frame (line 0, h_cnt=0).
- Per line, in FLUSH or READ, with h = h_cnt:
  - afe_hd=0 when h==0;
  - afe_pblk=0 when h<H_BLANK; afe_pblk=1 otherwise, but only in READ (FLUSH keeps pblk=0 for the whole line);
  - transfers: FLUSH always does 1 transfer per line, READ does nb;
  - transfer j occupies h in [j*VXFER_LEN, (j+1)*VXFER_LEN);
  - ccd_v1=1 in the first VXFER_LEN/2 cycles of each transfer, ccd_v2=1 in the second half;
  - any transfer portion at h>=H_BLANK is suppressed, so v1 and v2 are never high during the active interval;
  - READ only:
    - afe_clpob=0 for H_BLANK<=h<H_BLANK+CLPOB_LEN;
    - cpu_hsync=1 for h>=H_BLANK;
    - cpu_vsync=1 for every cycle in READ.
- ccd_v1 and ccd_v2 are never simultaneously high.
- Frame length in output cycles = (V_DUMMY+V_LINES)*(H_BLANK+H_ACTIVE), independent of vbin.
- In IDLE all outputs hold their reset values.

Test Plan:
All scenarios use H_ACTIVE=16, H_BLANK=12, V_LINES=4, V_DUMMY=2, VXFER_LEN=4, CLPOB_LEN=2, so a line is 28 cycles.
- Reset, then trigger=1 for 1 cycle with vbin=0:
  - busy high for exactly 168 cycles, then done=1 for 1 cycle with busy=0;
  - afe_vd low exactly once, on the first busy cycle;
  - 6 afe_hd pulses, spaced 28 cycles apart.
- Same run:
  - afe_pblk low for all 56 cycles of the dummy lines;
  - each active line: afe_pblk low 12 cycles, then high 16;
  - afe_clpob low exactly 2 cycles after each pblk rise (4 windows total);
  - cpu_hsync high 16 cycles per active line;
  - cpu_vsync high 112 contiguous cycles.
- vbin=2 (3 rows per line):
  - 14 ccd_v1 pulses total (2 dummy + 4×3), each 2 cycles, each followed directly by a 2-cycle ccd_v2 pulse;
  - on active lines, v1/v2 activity ends at h=11;
  - frame still 168 cycles.
- vbin=3 (4 transfers, overflow):
  - active lines carry only 3 complete transfers (12 blank cycles);
  - v1/v2 stay 0 whenever cpu_hsync=1.
- Assert rst for 1 cycle at output cycle 60 of a frame:
  - next cycle shows all reset values;
  - no done pulse occurs;
  - a new trigger then yields a full 168-cycle frame.
- trigger held high continuously:
  - frames run back to back, separated by the single FIN cycle plus the IDLE acceptance cycle;
  - toggling trigger mid-frame has no effect.

Source files
------------

// File: rtl/timgen_frame_seq_if.sv
// Framing bus of the frame readout sequencer: trigger/binning request in,
// busy/done handshake and AFE/CCD/CPU timing strobes out.
interface timgen_frame_seq_if;
    logic       trigger;
    logic [1:0] vbin;
    logic       busy;
    logic       done;
    logic       afe_hd;
    logic       afe_pblk;
    logic       afe_clpob;
    logic       afe_vd;
    logic       ccd_v1;
    logic       ccd_v2;
    logic       cpu_hsync;
    logic       cpu_vsync;

    modport master (
        output trigger, vbin,
        input  busy, done, afe_hd, afe_pblk, afe_clpob, afe_vd,
               ccd_v1, ccd_v2, cpu_hsync, cpu_vsync
    );

    modport slave (
        input  trigger, vbin,
        output busy, done, afe_hd, afe_pblk, afe_clpob, afe_vd,
               ccd_v1, ccd_v2, cpu_hsync, cpu_vsync
    );
endinterface

// File: rtl/timgen_frame_seq.sv
// Frame readout sequencer: flush lines then active lines, each a blanking
// interval with vertical transfers followed by the active pixel interval.
module timgen_frame_seq #(
    parameter int unsigned H_ACTIVE  = 4000,
    parameter int unsigned H_BLANK   = 96,
    parameter int unsigned V_LINES   = 2700,
    parameter int unsigned V_DUMMY   = 8,
    parameter int unsigned VXFER_LEN = 16,
    parameter int unsigned CLPOB_LEN = 16
) (
    input  logic               clk_pix,
    input  logic               rst,
    timgen_frame_seq_if.slave  bus
);
    localparam int unsigned H_TOT = H_BLANK + H_ACTIVE;
    localparam int unsigned L_MAX = (V_DUMMY > V_LINES) ? V_DUMMY : V_LINES;
    localparam int unsigned HW    = $clog2(H_TOT);
    localparam int unsigned LW    = (L_MAX > 1) ? $clog2(L_MAX) : 1;
    localparam int unsigned PW    = $clog2(VXFER_LEN);

    typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_READ, ST_FIN} state_t;
    localparam state_t FIRST_ST = (V_DUMMY == 0) ? ST_READ : ST_FLUSH;

    state_t          r_state;
    logic [HW-1:0]   r_h_cnt;
    logic [LW-1:0]   r_l_cnt;
    logic [PW-1:0]   r_ph;
    logic [2:0]      r_xidx;
    logic [2:0]      r_nb;

    logic r_busy, r_done, r_hd, r_pblk, r_clpob, r_vd;
    logic r_v1, r_v2, r_hsync, r_vsync;

    logic       w_run, w_read, w_blank, w_clpob_win, w_first;
    logic       w_h_last, w_line_last, w_xfer_on, w_ph_lo;
    logic [2:0] w_nx;

    assign w_run       = (r_state == ST_FLUSH) || (r_state == ST_READ);
    assign w_read      = (r_state == ST_READ);
    assign w_blank     = (r_h_cnt < HW'(H_BLANK));
    assign w_clpob_win = ({1'b0, r_h_cnt} < (HW+1)'(H_BLANK + CLPOB_LEN));
    assign w_first     = (r_state == FIRST_ST) && (r_h_cnt == '0) && (r_l_cnt == '0);
    assign w_h_last    = (r_h_cnt == HW'(H_TOT - 1));
    assign w_line_last = w_read ? (r_l_cnt == LW'(V_LINES - 1))
                                : (r_l_cnt == LW'(V_DUMMY - 1));
    assign w_nx        = w_read ? r_nb : 3'd1;
    // r_ph/r_xidx track h_cnt mod / div VXFER_LEN without a divider
    assign w_xfer_on   = w_run && w_blank && (r_xidx < w_nx);
    assign w_ph_lo     = (r_ph < PW'(VXFER_LEN / 2));

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_h_cnt <= '0;
            r_l_cnt <= '0;
            r_ph    <= '0;
            r_xidx  <= '0;
            r_nb    <= 3'd1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hd    <= 1'b1;
            r_pblk  <= 1'b0;
            r_clpob <= 1'b1;
            r_vd    <= 1'b1;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_hsync <= 1'b0;
            r_vsync <= 1'b0;
        end else begin
            r_busy  <= w_run;
            r_done  <= (r_state == ST_FIN);
            r_hd    <= !(w_run && (r_h_cnt == '0));
            r_pblk  <= w_read && !w_blank;
            r_clpob <= !(w_read && !w_blank && w_clpob_win);
            r_vd    <= !w_first;
            r_v1    <= w_xfer_on && w_ph_lo;
            r_v2    <= w_xfer_on && !w_ph_lo;
            r_hsync <= w_read && !w_blank;
            r_vsync <= w_read;

            case (r_state)
                ST_IDLE: begin
                    if (bus.trigger) begin
                        r_nb    <= {1'b0, bus.vbin} + 3'd1;
                        r_state <= FIRST_ST;
                        r_h_cnt <= '0;
                        r_l_cnt <= '0;
                        r_ph    <= '0;
                        r_xidx  <= '0;
                    end
                end
                ST_FLUSH, ST_READ: begin
                    if (w_h_last) begin
                        r_h_cnt <= '0;
                        r_ph    <= '0;
                        r_xidx  <= '0;
                        if (w_line_last) begin
                            r_l_cnt <= '0;
                            r_state <= w_read ? ST_FIN : ST_READ;
                        end else begin
                            r_l_cnt <= r_l_cnt + LW'(1);
                        end
                    end else begin
                        r_h_cnt <= r_h_cnt + HW'(1);
                        if (r_ph == PW'(VXFER_LEN - 1)) begin
                            r_ph <= '0;
                            if (r_xidx < 3'd4) r_xidx <= r_xidx + 3'd1;
                        end else begin
                            r_ph <= r_ph + PW'(1);
                        end
                    end
                end
                ST_FIN:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.afe_hd    = r_hd;
    assign bus.afe_pblk  = r_pblk;
    assign bus.afe_clpob = r_clpob;
    assign bus.afe_vd    = r_vd;
    assign bus.ccd_v1    = r_v1;
    assign bus.ccd_v2    = r_v2;
    assign bus.cpu_hsync = r_hsync;
    assign bus.cpu_vsync = r_vsync;
endmodule

// File: tb/tb_timgen_frame_seq.sv
// Scoreboard bench for timgen_frame_seq: a frame-position reference model
// queues the expected output vector for every clock edge.
module tb_timgen_frame_seq;
    localparam int HA = 16, HB = 12, VL = 4, VD = 2, VX = 4, CL = 2;
    localparam int LT    = HA + HB;
    localparam int FRAME = (VD + VL) * LT;
    // {busy, done, vd, hd, pblk, clpob, v1, v2, hsync, vsync}
    localparam logic [9:0] RST_VEC = 10'b0011010000;
    localparam logic [9:0] FIN_VEC = 10'b0111010000;

    logic clk_pix = 1'b0;
    logic rst;

    timgen_frame_seq_if bus();

    timgen_frame_seq #(
        .H_ACTIVE (HA),
        .H_BLANK  (HB),
        .V_LINES  (VL),
        .V_DUMMY  (VD),
        .VXFER_LEN(VX),
        .CLPOB_LEN(CL)
    ) dut (
        .clk_pix(clk_pix),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_pix = ~clk_pix;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: 0 idle, 1 running at frame cycle m_k, 2 fin
    int m_st   = 0;
    int m_k    = 0;
    int m_nb   = 1;
    int m_fins = 0;
    logic [9:0] sb_q[$];

    function automatic logic [9:0] model_out(input int st, input int k, input int nb);
        int   line, h, xf;
        logic rd, xon, lo;
        if (st == 0) return RST_VEC;
        if (st == 2) return FIN_VEC;
        line = k / LT;
        h    = k % LT;
        rd   = (line >= VD);
        xf   = rd ? nb : 1;
        xon  = (h < HB) && (h < xf * VX);
        lo   = (h % VX) < (VX / 2);
        return {1'b1, 1'b0, k != 0, h != 0, rd && h >= HB,
                !(rd && h >= HB && h < HB + CL),
                xon && lo, xon && !lo, rd && h >= HB, rd};
    endfunction

    task automatic drive(input logic t, input logic [1:0] vb, input logic r);
        @(negedge clk_pix);
        bus.trigger = t;
        bus.vbin    = vb;
        rst         = r;
        sb_q.push_back(r ? RST_VEC : model_out(m_st, m_k, m_nb));
        if (r) begin
            m_st = 0;
        end else begin
            case (m_st)
                0: if (t) begin m_st = 1; m_k = 0; m_nb = int'(vb) + 1; end
                1: if (m_k == FRAME - 1) begin m_st = 2; m_fins++; end else m_k++;
                default: m_st = 0;
            endcase
        end
    endtask

    int   cyc = 0;
    int   c_busy, c_vd, c_hd, c_pblk, c_cl, c_hs, c_vs, c_v1;
    int   c_done = 0;
    logic prev_busy = 1'b0;
    logic prev_v1   = 1'b0;

    initial begin
        logic [9:0] e, o;
        int         nx;
        forever begin
            @(posedge clk_pix);
            #1;
            cyc++;
            o = {bus.busy, bus.done, bus.afe_vd, bus.afe_hd, bus.afe_pblk, bus.afe_clpob,
                 bus.ccd_v1, bus.ccd_v2, bus.cpu_hsync, bus.cpu_vsync};
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_eq($sformatf("outs@%0d", cyc), 32'(o), 32'(e));
                check_eq($sformatf("v_excl@%0d", cyc),
                         {30'd0, bus.ccd_v1 & bus.ccd_v2,
                          (bus.ccd_v1 | bus.ccd_v2) & bus.cpu_hsync}, 32'd0);
            end
            if (bus.busy && !prev_busy) begin
                c_busy = 0; c_vd = 0; c_hd = 0; c_pblk = 0;
                c_cl = 0; c_hs = 0; c_vs = 0; c_v1 = 0;
            end
            if (bus.busy) begin
                c_busy++;
                if (!bus.afe_vd)    c_vd++;
                if (!bus.afe_hd)    c_hd++;
                if (!bus.afe_pblk)  c_pblk++;
                if (!bus.afe_clpob) c_cl++;
                if (bus.cpu_hsync)  c_hs++;
                if (bus.cpu_vsync)  c_vs++;
                if (bus.ccd_v1 && !prev_v1) c_v1++;
            end
            if (bus.done) begin
                c_done++;
                nx = (m_nb < 3) ? m_nb : 3;
                check_eq("frame_len", c_busy, FRAME);
                check_eq("vd_lows",   c_vd, 1);
                check_eq("hd_pulses", c_hd, VD + VL);
                check_eq("pblk_lows", c_pblk, VD * LT + VL * HB);
                check_eq("clpob_lows", c_cl, VL * CL);
                check_eq("hsync_hi",  c_hs, VL * HA);
                check_eq("vsync_hi",  c_vs, VL * LT);
                check_eq("v1_pulses", c_v1, VD + VL * nx);
                check_eq("done_busy", 32'(bus.busy), 32'd0);
            end
            prev_busy = bus.busy;
            prev_v1   = bus.ccd_v1;
        end
    end

    initial begin
        bus.trigger = 1'b0;
        bus.vbin    = 2'd0;
        rst         = 1'b1;
        repeat (2) drive(1'b0, 2'd0, 1'b1);
        repeat (3) drive(1'b0, 2'd0, 1'b0);
        // basic frame, 3-row binning, 4-row overflow binning
        drive(1'b1, 2'd0, 1'b0);
        repeat (FRAME + 4) drive(1'b0, 2'd0, 1'b0);
        drive(1'b1, 2'd2, 1'b0);
        repeat (FRAME + 4) drive(1'b0, 2'd3, 1'b0);
        drive(1'b1, 2'd3, 1'b0);
        repeat (FRAME + 4) drive(1'b0, 2'd0, 1'b0);
        // abort mid-frame, then a clean frame
        drive(1'b1, 2'd1, 1'b0);
        repeat (60) drive(1'b0, 2'd0, 1'b0);
        drive(1'b0, 2'd0, 1'b1);
        repeat (4) drive(1'b0, 2'd0, 1'b0);
        drive(1'b1, 2'd0, 1'b0);
        repeat (FRAME + 4) drive(1'b0, 2'd0, 1'b0);
        // back-to-back frames, then trigger toggling during frames
        repeat (3 * (FRAME + 2)) drive(1'b1, 2'($urandom_range(0, 3)), 1'b0);
        repeat (2 * (FRAME + 2))
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0);
        repeat (FRAME + 4) drive(1'b0, 2'd0, 1'b0);
        @(posedge clk_pix);
        #2;
        check_eq("sb_empty", sb_q.size(), 0);
        check_eq("done_cnt", c_done, m_fins);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
